// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU front-end sequencer: FSM states, ALU opcodes
// and bit positions within the {N,Z,C,V,P} flag vector.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_CALC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

  localparam logic [1:0] OP_SUB = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  localparam int F_N = 4;
  localparam int F_Z = 3;
  localparam int F_C = 2;
  localparam int F_V = 1;
  localparam int F_P = 0;

endpackage

// File: rtl/btn_edge_pulse.sv
// One-cycle pulse on the rising edge of a debounced button level. The history
// register resets high so a button held through reset never produces a pulse.
module btn_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (reset) r_level_q <= 1'b1;
    else       r_level_q <= i_level;
  end

  assign o_pulse = i_level & ~r_level_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Collects A, B and opcode from the switch bus with Enter/Undo, drives the
// external ALU from registered operands and latches its result for display.
//
// state      | meaning
// WAIT_A     | showing switches, Enter captures operand A
// WAIT_B     | showing switches, Enter captures operand B, Undo back to A
// WAIT_OP    | showing data_in[1:0], Enter captures opcode, Undo back to B
// CALC       | one cycle: latch ALU result/flags, bump op counter
// SHOW       | result and flags shown; Enter starts over, Undo re-picks opcode
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int M     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [M-1:0]     data_in,
  input  logic             enter_btn,
  input  logic             undo_btn,
  output logic [M-1:0]     alu_a,
  output logic [M-1:0]     alu_b,
  output logic [1:0]       alu_op,
  input  logic [M-1:0]     alu_result,
  input  logic [4:0]       alu_flags,
  output logic [M-1:0]     display_value,
  output logic [4:0]       flags_out,
  output logic [2:0]       state_out,
  output logic             result_valid,
  output logic [CNT_W-1:0] op_count
);

  state_e           r_state;
  logic [M-1:0]     r_a, r_b, r_res;
  logic [1:0]       r_op;
  logic [4:0]       r_flg;
  logic [CNT_W-1:0] r_count;
  logic             w_enter_p, w_undo_p, w_enter, w_undo;

  btn_edge_pulse u_enter_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (enter_btn),
    .o_pulse (w_enter_p)
  );

  btn_edge_pulse u_undo_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (undo_btn),
    .o_pulse (w_undo_p)
  );

  // Simultaneous Enter and Undo is ambiguous, so both are dropped.
  assign w_enter = w_enter_p & ~w_undo_p;
  assign w_undo  = w_undo_p & ~w_enter_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_WAIT_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_flg   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_WAIT_A: begin
          if (w_enter) begin
            r_a     <= data_in;
            r_state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (w_enter) begin
            r_b     <= data_in;
            r_state <= ST_WAIT_OP;
          end else if (w_undo) begin
            r_state <= ST_WAIT_A;
          end
        end
        ST_WAIT_OP: begin
          if (w_enter) begin
            r_op    <= data_in[1:0];
            r_state <= ST_CALC;
          end else if (w_undo) begin
            r_state <= ST_WAIT_B;
          end
        end
        ST_CALC: begin
          r_res   <= alu_result;
          r_flg   <= alu_flags;
          if (r_count != '1) r_count <= r_count + 1'b1;
          r_state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (w_enter)     r_state <= ST_WAIT_A;
          else if (w_undo) r_state <= ST_WAIT_OP;
        end
        default: r_state <= ST_WAIT_A;
      endcase
    end
  end

  always_comb begin
    display_value = data_in;
    case (r_state)
      ST_WAIT_OP: display_value = {{(M-2){1'b0}}, data_in[1:0]};
      ST_CALC:    display_value = r_b;
      ST_SHOW:    display_value = r_res;
      default:    display_value = data_in;
    endcase
  end

  assign result_valid = (r_state == ST_SHOW);
  assign flags_out    = result_valid ? r_flg : 5'b0;
  assign state_out    = r_state;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_op       = r_op;
  assign op_count     = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 8-bit team ALU;
// expected SHOW results are queued by stimulus and checked by a monitor.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       enter_btn, undo_btn;
  logic [7:0] alu_a, alu_b, alu_result, display_value, op_count;
  logic [1:0] alu_op;
  logic [4:0] alu_flags, flags_out;
  logic [2:0] state_out;
  logic       result_valid;

  alu_op_sequencer #(.M(8), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .enter_btn     (enter_btn),
    .undo_btn      (undo_btn),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_flags     (alu_flags),
    .display_value (display_value),
    .flags_out     (flags_out),
    .state_out     (state_out),
    .result_valid  (result_valid),
    .op_count      (op_count)
  );

  always #5 clk = ~clk;

  // Team ALU: sub C is the borrow, P is odd parity of the result.
  always_comb begin
    logic [8:0] wide;
    logic       v;
    wide = 9'd0;
    v    = 1'b0;
    case (alu_op)
      2'd0: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        v = (alu_a[7] != alu_b[7]) && (wide[7] != alu_a[7]);
      end
      2'd1: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        v = (alu_a[7] == alu_b[7]) && (wide[7] != alu_a[7]);
      end
      2'd2: wide = {1'b0, alu_a | alu_b};
      default: wide = {1'b0, alu_a & alu_b};
    endcase
    alu_result = wide[7:0];
    alu_flags  = {wide[7], (wide[7:0] == 8'd0), wide[8], v, ^wide[7:0]};
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] disp;
    logic [4:0] flg;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: a rising result_valid is the DUT presenting a result.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_show", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("show_display", 32'(display_value), 32'(e.disp));
          check("show_flags",   32'(flags_out),     32'(e.flg));
          check("show_count",   32'(op_count),      32'(e.cnt));
          check("show_alu_a",   32'(alu_a),         32'(e.a));
          check("show_alu_b",   32'(alu_b),         32'(e.b));
          check("show_alu_op",  32'(alu_op),        32'(e.op));
        end
      end
      prev_valid = result_valid;
    end
  end

  task automatic press_enter(input logic [7:0] val);
    @(negedge clk);
    data_in   = val;
    enter_btn = 1'b1;
    @(negedge clk);
    enter_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_undo();
    @(negedge clk);
    undo_btn = 1'b1;
    @(negedge clk);
    undo_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_both(input logic [7:0] val);
    @(negedge clk);
    data_in   = val;
    enter_btn = 1'b1;
    undo_btn  = 1'b1;
    @(negedge clk);
    enter_btn = 1'b0;
    undo_btn  = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic [7:0] disp, input logic [4:0] flg, input logic [7:0] cnt);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.disp = disp; e.flg = flg; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // From WAIT_A: enter A, B, opcode and wait for the result in SHOW.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [7:0] disp, input logic [4:0] flg, input logic [7:0] cnt);
    push_exp(a, b, op, disp, flg, cnt);
    press_enter(a);
    press_enter(b);
    press_enter({6'd0, op});
    wait_drained();
  endtask

  initial begin
    reset     = 1'b1;
    data_in   = 8'h5A;
    enter_btn = 1'b1;
    undo_btn  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_state",   32'(state_out),     32'd0);
    check("rst_alu_a",   32'(alu_a),         32'd0);
    check("rst_alu_b",   32'(alu_b),         32'd0);
    check("rst_alu_op",  32'(alu_op),        32'd0);
    check("rst_flags",   32'(flags_out),     32'd0);
    check("rst_count",   32'(op_count),      32'd0);
    check("rst_valid",   32'(result_valid),  32'd0);
    check("rst_display", 32'(display_value), 32'h5A);

    // Enter held through reset, released afterwards: no transition.
    repeat (3) @(negedge clk);
    enter_btn = 1'b0;
    repeat (3) @(negedge clk);
    check("held_thru_reset_state", 32'(state_out), 32'd0);

    do_op(8'd5, 8'd3, 2'd1, 8'd8, 5'b00001, 8'd1);
    press_enter(8'h00);
    check("show_enter_state", 32'(state_out), 32'd0);

    do_op(8'd3, 8'd5, 2'd0, 8'hFE, 5'b10101, 8'd2);
    press_enter(8'h00);

    do_op(8'h80, 8'h80, 2'd1, 8'h00, 5'b01110, 8'd3);
    press_undo();
    check("show_undo_state", 32'(state_out), 32'd2);
    @(negedge clk);
    data_in = 8'hFF;
    @(negedge clk);
    check("waitop_display", 32'(display_value), 32'd3);
    push_exp(8'h80, 8'h80, 2'd3, 8'h80, 5'b10001, 8'd4);
    press_enter(8'd3);
    wait_drained();
    press_enter(8'h00);

    // Undo chain.
    press_enter(8'd7);
    check("undo_chain_wait_b", 32'(state_out), 32'd1);
    @(negedge clk);
    data_in = 8'd9;
    press_undo();
    check("undo_chain_state", 32'(state_out), 32'd0);
    check("undo_chain_a_kept", 32'(alu_a), 32'd7);
    press_undo();
    check("undo_in_wait_a", 32'(state_out), 32'd0);
    press_both(8'h33);
    check("both_state", 32'(state_out), 32'd0);
    check("both_a_kept", 32'(alu_a), 32'd7);

    // Enter held 50 cycles: exactly one step.
    @(negedge clk);
    data_in   = 8'h11;
    enter_btn = 1'b1;
    repeat (50) @(negedge clk);
    enter_btn = 1'b0;
    repeat (2) @(negedge clk);
    check("held_state", 32'(state_out), 32'd1);
    check("held_a", 32'(alu_a), 32'h11);

    // Reset in WAIT_OP.
    press_enter(8'h22);
    check("pre_rst_waitop", 32'(state_out), 32'd2);
    pulse_reset();
    check("rst_waitop_state", 32'(state_out), 32'd0);
    check("rst_waitop_flags", 32'(flags_out), 32'd0);
    check("rst_waitop_count", 32'(op_count),  32'd0);
    check("rst_waitop_a",     32'(alu_a),     32'd0);
    check("rst_waitop_b",     32'(alu_b),     32'd0);

    // Reset in SHOW.
    do_op(8'd1, 8'd2, 2'd1, 8'd3, 5'b00000, 8'd1);
    pulse_reset();
    check("rst_show_state", 32'(state_out),    32'd0);
    check("rst_show_flags", 32'(flags_out),    32'd0);
    check("rst_show_count", 32'(op_count),     32'd0);
    check("rst_show_valid", 32'(result_valid), 32'd0);
    check("rst_show_a",     32'(alu_a),        32'd0);
    check("rst_show_b",     32'(alu_b),        32'd0);

    // Counter saturation: AND with zero always gives 0 with only Z set.
    for (int i = 1; i <= 257; i++) begin
      do_op(8'(i), 8'h00, 2'd3, 8'h00, 5'b01000, (i > 255) ? 8'd255 : 8'(i));
      press_enter(8'h00);
    end
    check("sat_count", 32'(op_count), 32'd255);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
